// File: rtl/uart_rx_fsm_if.sv
// Receive-side bundle of uart_rx_fsm: data/strobe/status toward the data sink.
// master = the frame controller driving these signals, slave = the sink.
interface uart_rx_fsm_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] rx_data;
    logic              data_valid;
    logic              parity_error;
    logic              stop_error;
    logic              busy;

    modport master (
        output rx_data,
        output data_valid,
        output parity_error,
        output stop_error,
        output busy
    );

    modport slave (
        input rx_data,
        input data_valid,
        input parity_error,
        input stop_error,
        input busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver frame controller. Detects the start edge, runs
// the per-bit edge counter for the oversampling sampler, deserializes DWIDTH
// bits LSB-first, checks optional parity and the stop bit.
// Optional feature macro: UART_RX_PARITY_EN (parity state and check compiled in).
module uart_rx_fsm #(
    parameter int PWIDTH = 6,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              sampled_bit,
    output logic [PWIDTH-1:0] edge_counter,
    output logic              data_sampling_en,
    uart_rx_fsm_if.master     rx_if
);
    localparam int BW = $clog2(DWIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;

    // Expected parity bit: even -> XOR of data, odd -> inverted XOR.
    function automatic logic calc_parity(input logic [DWIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

    logic [2:0]        state_q, state_d;
    logic [PWIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [DWIDTH-1:0] rx_data_q, rx_data_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_error_q, parity_error_d;
    logic              stop_error_q, stop_error_d;
    logic              busy_q, busy_d;
    logic              sampling_en_q, sampling_en_d;
    logic              bit_end_s;
`ifdef UART_RX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
`else
    logic              unused_par_s;
    assign unused_par_s = par_en ^ par_typ;
`endif

    assign bit_end_s = (edge_cnt_q == (prescale - PWIDTH'(1)));

    // Next-state, counter, shift register and flag computation.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;
`ifdef UART_RX_PARITY_EN
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
`endif

        // Edge counter idles at 0 and free-runs modulo prescale in a frame.
        if (state_q == ST_IDLE) begin
            edge_cnt_d = {PWIDTH{1'b0}};
        end else if (bit_end_s) begin
            edge_cnt_d = {PWIDTH{1'b0}};
        end else begin
            edge_cnt_d = edge_cnt_q + PWIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d        = ST_START;
                    parity_error_d = 1'b0;
                    stop_error_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_en_d       = par_en;
                    par_typ_d      = par_typ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    if (!sampled_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = {BW{1'b0}};
                    end else begin
                        // Start bit did not hold: treat as a line glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d   = {sampled_bit, shift_q[DWIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DWIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    if (sampled_bit != calc_parity(shift_q, par_typ_q)) begin
                        parity_error_d = 1'b1;
                    end else begin
                        parity_error_d = parity_error_q;
                    end
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    if (!sampled_bit) begin
                        stop_error_d = 1'b1;
                    end else if (!parity_error_q) begin
                        rx_data_d    = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        rx_data_d = rx_data_q;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifndef UART_RX_PARITY_EN
        parity_error_d = 1'b0;
`endif
        busy_d        = (state_d != ST_IDLE);
        sampling_en_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= {PWIDTH{1'b0}};
            bit_cnt_q      <= {BW{1'b0}};
            shift_q        <= {DWIDTH{1'b0}};
            rx_data_q      <= {DWIDTH{1'b0}};
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
            sampling_en_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            busy_q         <= busy_d;
            sampling_en_q  <= sampling_en_d;
`ifdef UART_RX_PARITY_EN
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
`endif
        end
    end

    assign edge_counter       = edge_cnt_q;
    assign data_sampling_en   = sampling_en_q;
    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.data_valid   = data_valid_q;
    assign rx_if.parity_error = parity_error_q;
    assign rx_if.stop_error   = stop_error_q;
    assign rx_if.busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm. The bench plays both the
// serial line and the majority-vote sampler (sampled_bit is the line value
// of the bit period that is ending).
module tb_uart_rx_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic [5:0] edge_counter;
    logic       data_sampling_en;

    uart_rx_fsm_if #(.DWIDTH(8)) rx_if ();

    uart_rx_fsm #(.PWIDTH(6), .DWIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_in            (rx_in),
        .prescale         (prescale),
        .par_en           (par_en),
        .par_typ          (par_typ),
        .sampled_bit      (sampled_bit),
        .edge_counter     (edge_counter),
        .data_sampling_en (data_sampling_en),
        .rx_if            (rx_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int start_cyc    = 0;
    int dv_q[$];
    logic [7:0] last_byte;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_if.data_valid === 1'b1) dv_q.push_back(cyc);
    end

    // Drive one frame; start edge is sampled at the posedge after the first negedge.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_on,
                              input logic par_bit, input logic stop_bit);
        logic bits [11];
        int   nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (par_on) begin
            bits[9]  = par_bit;
            bits[10] = stop_bit;
            nb = 11;
        end else begin
            bits[9]  = stop_bit;
            bits[10] = 1'b1;
            nb = 10;
        end
        for (int c = 0; c < nb * p; c++) begin
            @(negedge clk);
            if (c == 0) start_cyc = cyc + 1;
            rx_in       = bits[c / p];
            sampled_bit = (c == 0) ? 1'b1 : bits[(c - 1) / p];
        end
        @(negedge clk);
        rx_in       = 1'b1;
        sampled_bit = bits[nb - 1];
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_in = 1'b1; sampled_bit = 1'b1;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rx_if.busy, data_sampling_en, rx_if.data_valid, rx_if.parity_error, rx_if.stop_error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {rx_if.busy, data_sampling_en, rx_if.data_valid, rx_if.parity_error, rx_if.stop_error});
        end
        tests_run++;
        if (rx_if.rx_data !== 8'h00 || edge_counter !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_data: rx_data=%h ec=%0d expected 00/0", rx_if.rx_data, edge_counter);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int n0;
        n0 = dv_q.size();
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dv_q.size() !== n0 + 1) begin
            tests_failed++;
            $display("FAIL good_dv_count: got %0d strobes expected 1", dv_q.size() - n0);
        end else begin
            tests_run++;
            if (dv_q[n0] - start_cyc !== 80) begin
                tests_failed++;
                $display("FAIL good_latency: got %0d expected 80", dv_q[n0] - start_cyc);
            end
        end
        tests_run++;
        if (rx_if.rx_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL good_data: got %h expected a5", rx_if.rx_data);
        end
        tests_run++;
        if (rx_if.parity_error !== 1'b0 || rx_if.stop_error !== 1'b0 || rx_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_flags: pe=%b se=%b busy=%b expected 0/0/0", rx_if.parity_error, rx_if.stop_error, rx_if.busy);
        end
        last_byte = 8'hA5;
    endtask

    task automatic test_parity();
        int n0;
        n0 = dv_q.size();
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
`ifdef UART_RX_PARITY_EN
        tests_run++;
        if (rx_if.parity_error !== 1'b1 || dv_q.size() !== n0) begin
            tests_failed++;
            $display("FAIL parity_err: pe=%b strobes=%0d expected 1/0", rx_if.parity_error, dv_q.size() - n0);
        end
        tests_run++;
        if (rx_if.rx_data !== last_byte) begin
            tests_failed++;
            $display("FAIL parity_keep: got %h expected %h", rx_if.rx_data, last_byte);
        end
        n0 = dv_q.size();
        par_typ = 1'b1;
        send_frame(8'h07, 16, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dv_q.size() !== n0 + 1 || rx_if.rx_data !== 8'h07 || rx_if.parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_odd_ok: strobes=%0d data=%h pe=%b expected 1/07/0", dv_q.size() - n0, rx_if.rx_data, rx_if.parity_error);
        end else begin
            tests_run++;
            if (dv_q[n0] - start_cyc !== 176) begin
                tests_failed++;
                $display("FAIL parity_latency: got %0d expected 176", dv_q[n0] - start_cyc);
            end
        end
        last_byte = 8'h07;
`else
        tests_run++;
        if (rx_if.parity_error !== 1'b0 || dv_q.size() !== n0 + 1 || rx_if.rx_data !== 8'h03) begin
            tests_failed++;
            $display("FAIL noparity_frame: pe=%b strobes=%0d data=%h expected 0/1/03", rx_if.parity_error, dv_q.size() - n0, rx_if.rx_data);
        end else begin
            tests_run++;
            if (dv_q[n0] - start_cyc !== 160) begin
                tests_failed++;
                $display("FAIL noparity_latency: got %0d expected 160", dv_q[n0] - start_cyc);
            end
        end
        last_byte = 8'h03;
`endif
        par_en = 1'b0; par_typ = 1'b0;
    endtask

    task automatic test_stop_error();
        int n0;
        n0 = dv_q.size();
        prescale = 6'd8;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        tests_run++;
        if (rx_if.stop_error !== 1'b1 || dv_q.size() !== n0) begin
            tests_failed++;
            $display("FAIL stop_err: se=%b strobes=%0d expected 1/0", rx_if.stop_error, dv_q.size() - n0);
        end
        tests_run++;
        if (rx_if.rx_data !== last_byte || rx_if.parity_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_keep: data=%h pe=%b expected %h/0", rx_if.rx_data, rx_if.parity_error, last_byte);
        end
        n0 = dv_q.size();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (rx_if.stop_error !== 1'b0 || dv_q.size() !== n0 + 1 || rx_if.rx_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL stop_recover: se=%b strobes=%0d data=%h expected 0/1/3c", rx_if.stop_error, dv_q.size() - n0, rx_if.rx_data);
        end
        last_byte = 8'h3C;
    endtask

    task automatic test_glitch();
        int n0;
        int busy_cnt;
        n0 = dv_q.size();
        busy_cnt = 0;
        prescale = 6'd8;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rx_if.busy === 1'b1) busy_cnt++;
            if (c == 0) begin
                tests_run++;
                if (data_sampling_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL glitch_idle_en: got %b expected 0", data_sampling_en);
                end
            end
            if (c == 1) begin
                tests_run++;
                if (data_sampling_en !== 1'b1 || rx_if.busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL glitch_rise: en=%b busy=%b expected 1/1", data_sampling_en, rx_if.busy);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (edge_counter !== 6'd3) begin
                    tests_failed++;
                    $display("FAIL glitch_edge_cnt: got %0d expected 3", edge_counter);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (rx_if.busy !== 1'b0 || edge_counter !== 6'd0) begin
                    tests_failed++;
                    $display("FAIL glitch_idle: busy=%b ec=%0d expected 0/0", rx_if.busy, edge_counter);
                end
            end
            rx_in       = (c < 3) ? 1'b0 : 1'b1;
            sampled_bit = 1'b1;
        end
        tests_run++;
        if (busy_cnt !== 8) begin
            tests_failed++;
            $display("FAIL glitch_busy_len: got %0d expected 8", busy_cnt);
        end
        tests_run++;
        if (dv_q.size() !== n0 || rx_if.stop_error !== 1'b0 || rx_if.parity_error !== 1'b0 || rx_if.rx_data !== last_byte) begin
            tests_failed++;
            $display("FAIL glitch_noeffect: strobes=%0d se=%b pe=%b data=%h expected 0/0/0/%h", dv_q.size() - n0, rx_if.stop_error, rx_if.parity_error, rx_if.rx_data, last_byte);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = dv_q.size();
        prescale = 6'd8;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests_run++;
        if (dv_q.size() !== n0 + 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d strobes expected 2", dv_q.size() - n0);
        end else begin
            tests_run++;
            if (dv_q[n0 + 1] - dv_q[n0] !== 81) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d expected 81", dv_q[n0 + 1] - dv_q[n0]);
            end
        end
        tests_run++;
        if (rx_if.rx_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h expected ff", rx_if.rx_data);
        end
        last_byte = 8'hFF;
    endtask

    task automatic test_mid_reset();
        prescale = 6'd8;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rx_in       = 1'b0;
            sampled_bit = 1'b0;
        end
        tests_run++;
        if (rx_if.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy_before: got %b expected 1", rx_if.busy);
        end
        rst = 1'b0; rx_in = 1'b1; sampled_bit = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tests_run++;
        if ({rx_if.busy, data_sampling_en, rx_if.data_valid, rx_if.parity_error, rx_if.stop_error} !== 5'b0 || edge_counter !== 6'd0) begin
            tests_failed++;
            $display("FAIL midrst_state: busy/en/dv/pe/se=%b ec=%0d expected 00000/0", {rx_if.busy, data_sampling_en, rx_if.data_valid, rx_if.parity_error, rx_if.stop_error}, edge_counter);
        end
        tests_run++;
        if (rx_if.rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_data: got %h expected 00", rx_if.rx_data);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (rx_if.busy !== 1'b0 || edge_counter !== 6'd0) begin
            tests_failed++;
            $display("FAIL midrst_stay_idle: busy=%b ec=%0d expected 0/0", rx_if.busy, edge_counter);
        end
    endtask

    initial begin
        last_byte = 8'h00;
        test_reset();
        test_good_frame();
        test_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
